// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the 8-bit datapath: fetches over req/ack, holds the IR,
// drives one datapath strobe per phase, counts retirements and flags fetch timeouts.
module multicycle_control_unit #(
   parameter int INSTR_W       = 8,
   parameter int CNT_W         = 16,
   parameter int FETCH_TIMEOUT = 15
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Run,
   input  logic               Halt_Req,
   input  logic               Imem_Ack,
   input  logic [INSTR_W-1:0] Imem_Data,
   output logic               Imem_Req,
   output logic [INSTR_W-1:0] Instruction_Code,
   output logic               PCWrite,
   output logic               PCSrc,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               ALUSrc,
   output logic               ImmSel,
   output logic               Busy,
   output logic               Error,
   output logic [CNT_W-1:0]   Instr_Count,
   output logic [2:0]         State
);

   localparam int WAIT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      WB     = 3'd4,
      JUMP   = 3'd5,
      ERROR  = 3'd6
   } state_t;

   state_t              state, next_state;
   logic [INSTR_W-1:0]  ir;
   logic [CNT_W-1:0]    count;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                halt_pending;
   logic                retire;

   // Control-state register; IR loads only on an acknowledged fetch.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         ir           <= '0;
         count        <= '0;
         wait_cnt     <= '0;
         halt_pending <= 1'b0;
      end else begin
         state <= next_state;
         if (IRWrite)
            ir <= Imem_Data;
         if (retire)
            count <= count + 1'b1;
         // Counter is zero whenever FETCH is entered, since it clears outside FETCH.
         if (state == FETCH && !Imem_Ack)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if (next_state == IDLE)
            halt_pending <= 1'b0;
         else if (Busy && Halt_Req)
            halt_pending <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      Imem_Req   = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrc     = 1'b0;
      ImmSel     = 1'b0;
      retire     = 1'b0;
      case (state)
         IDLE: begin
            if (Run)
               next_state = FETCH;
         end
         FETCH: begin
            Imem_Req = 1'b1;
            if (Imem_Ack) begin
               IRWrite    = 1'b1;
               PCWrite    = 1'b1;
               next_state = DECODE;
            end else if (wait_cnt == WAIT_LAST) begin
               next_state = ERROR;
            end
         end
         DECODE: begin
            ImmSel     = ir[7];
            next_state = ir[7] ? JUMP : EXEC;
         end
         EXEC: begin
            ALUSrc     = ir[6];
            next_state = WB;
         end
         WB: begin
            RegWrite   = 1'b1;
            ALUSrc     = ir[6];
            retire     = 1'b1;
            next_state = (halt_pending || Halt_Req) ? IDLE : FETCH;
         end
         JUMP: begin
            // PC already holds PC+1 from FETCH; the datapath adds the jump offset.
            PCWrite    = 1'b1;
            PCSrc      = 1'b1;
            ImmSel     = 1'b1;
            retire     = 1'b1;
            next_state = (halt_pending || Halt_Req) ? IDLE : FETCH;
         end
         ERROR: begin
            next_state = ERROR;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign Busy             = (state != IDLE) && (state != ERROR);
   assign Error            = (state == ERROR);
   assign Instruction_Code = ir;
   assign Instr_Count      = count;
   assign State            = state;

endmodule
